// File: rtl/rr_trace_packet_aligner.sv
// Realigns a bit-packed replay trace stream into one zero-extended packet per output handshake.
// Packets are {payload, loge_valid, logb_valid}, LSB first; an all-zero header pads out the current word.
package rr_trace_packet_aligner_pkg;
   function automatic int sum_widths(input logic [1023:0] widths, input int count,
                                     input int width_bits);
      logic [1023:0] mask;
      int            total;
      total = 0;
      mask  = (1024'(1) << width_bits) - 1024'(1);
      for (int i = 0; i < count; i++)
         total += int'((widths >> (i * width_bits)) & mask);
      return total;
   endfunction
endpackage

module rr_trace_packet_aligner
   import rr_trace_packet_aligner_pkg::*;
#(
   parameter int IN_WIDTH              = 512,
   parameter int LOGB_CHANNEL_CNT      = 2,
   parameter int LOGE_CHANNEL_CNT      = 2,
   parameter int RR_CHANNEL_WIDTH_BITS = 16,
   parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {16'd16, 16'd8},
   localparam int HDR_W      = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
   localparam int FULL_WIDTH = sum_widths(1024'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT, RR_CHANNEL_WIDTH_BITS),
   localparam int PKT_MAX    = HDR_W + FULL_WIDTH
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                in_valid,
   input  logic [IN_WIDTH-1:0] in_data,
   output logic                in_ready,
   output logic                out_valid,
   output logic [PKT_MAX-1:0]  out_data,
   input  logic                out_ready,
   output logic [31:0]         pkt_cnt
);
   localparam int BUF_W = PKT_MAX + IN_WIDTH;
   localparam int CNT_W = $clog2(BUF_W + 1) + 1;
   localparam int OFF_W = $clog2(IN_WIDTH + 1);
   localparam logic [CNT_W-1:0] HDR_LEN     = CNT_W'(HDR_W);
   localparam logic [CNT_W-1:0] PKT_MAX_LEN = CNT_W'(PKT_MAX);
   localparam logic [CNT_W-1:0] IN_LEN      = CNT_W'(IN_WIDTH);

   logic [BUF_W-1:0]   bit_buf_reg, bit_buf_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [OFF_W-1:0]   rd_off_reg, rd_off_next;
   logic               out_valid_reg;
   logic [PKT_MAX-1:0] out_data_reg;
   logic [31:0]        pkt_cnt_reg;

   logic [LOGB_CHANNEL_CNT-1:0][CNT_W-1:0] chan_len;
   logic [CNT_W-1:0]   pkt_len, drop_len, shift_len, cnt_rem, off_sum;
   logic [PKT_MAX-1:0] pkt_mask;
   logic               hdr_present, hdr_zero, do_drop, do_consume, accept;

   // Each set logb bit contributes its channel width to the payload length.
   generate
      for (genvar gi = 0; gi < LOGB_CHANNEL_CNT; gi++) begin : g_chan
         assign chan_len[gi] = bit_buf_reg[gi] ? CNT_W'(CHANNEL_WIDTHS[gi]) : '0;
      end
   endgenerate

   always_comb begin
      pkt_len = HDR_LEN;
      for (int i = 0; i < LOGB_CHANNEL_CNT; i++)
         pkt_len = pkt_len + chan_len[i];
      hdr_present = (cnt_reg >= HDR_LEN);
      hdr_zero    = (bit_buf_reg[HDR_W-1:0] == '0);
      drop_len    = IN_LEN - CNT_W'(rd_off_reg);
      do_drop     = hdr_present && hdr_zero && (cnt_reg >= drop_len);
      do_consume  = hdr_present && !hdr_zero && (cnt_reg >= pkt_len) && (!out_valid_reg || out_ready);
      shift_len   = do_consume ? pkt_len : (do_drop ? drop_len : '0);
      cnt_rem     = cnt_reg - shift_len;
      in_ready    = rstn && (cnt_rem <= PKT_MAX_LEN);
      accept      = in_valid && in_ready;
      // Shift out the retired bits first so the new word lands right after what remains.
      bit_buf_next = bit_buf_reg >> shift_len;
      cnt_next     = cnt_rem;
      if (accept) begin
         bit_buf_next = bit_buf_next | (BUF_W'(in_data) << cnt_rem);
         cnt_next     = cnt_rem + IN_LEN;
      end
      off_sum     = CNT_W'(rd_off_reg) + pkt_len;
      rd_off_next = rd_off_reg;
      if (do_consume)
         rd_off_next = OFF_W'(off_sum % IN_LEN);
      else if (do_drop)
         rd_off_next = '0;
      pkt_mask = {PKT_MAX{1'b1}} >> (PKT_MAX_LEN - pkt_len);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bit_buf_reg   <= '0;
         cnt_reg       <= '0;
         rd_off_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         pkt_cnt_reg   <= '0;
      end else begin
         bit_buf_reg <= bit_buf_next;
         cnt_reg     <= cnt_next;
         rd_off_reg  <= rd_off_next;
         if (do_consume) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= bit_buf_reg[PKT_MAX-1:0] & pkt_mask;
            pkt_cnt_reg   <= pkt_cnt_reg + 32'd1;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign pkt_cnt   = pkt_cnt_reg;
endmodule

// File: tb/tb_rr_trace_packet_aligner.sv
// Directed and randomised checks of rr_trace_packet_aligner with 64-bit words, channel widths 8 and 16.
module tb_rr_trace_packet_aligner;
   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [27:0] out_data;
   logic        out_ready;
   logic [31:0] pkt_cnt;

   int n_vec = 0;
   int n_err = 0;
   int exp_pkt_cnt = 0;

   logic [63:0] word_q[$];
   logic [27:0] exp_q[$];
   logic [27:0] got_q[$];
   int          got_cyc[$];

   rr_trace_packet_aligner #(
      .IN_WIDTH(64),
      .LOGB_CHANNEL_CNT(2),
      .LOGE_CHANNEL_CNT(2),
      .RR_CHANNEL_WIDTH_BITS(16),
      .CHANNEL_WIDTHS({16'd16, 16'd8})
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .pkt_cnt(pkt_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives word_q into the DUT and records every output handshake with its cycle index.
   task automatic stream(input int nexp, input int hold, input bit rand_v, input bit rand_r,
                         input int max_cycles, output bit timed_out, output int stalls);
      int widx = 0;
      int k = 0;
      int extra = 0;
      bit done;
      bit in_fire;
      timed_out = 1'b0;
      stalls = 0;
      got_q.delete();
      got_cyc.delete();
      while (1) begin
         @(negedge clk);
         done = (widx == word_q.size()) && (got_q.size() >= nexp);
         in_valid = (widx < word_q.size()) && (!rand_v || ($urandom_range(3) != 0));
         in_data = '0;
         if (in_valid) in_data = word_q[widx];
         out_ready = (k >= hold) && (done || !rand_r || ($urandom_range(3) != 0));
         #1;
         if (in_valid && !in_ready) stalls++;
         in_fire = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(k);
         end
         @(posedge clk);
         if (in_fire) widx++;
         k++;
         if ((widx == word_q.size()) && (got_q.size() >= nexp)) extra++;
         if (extra >= 6) break;
         if (k >= max_cycles) begin
            timed_out = 1'b1;
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rstn = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 28'h0 || pkt_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b data=%h cnt=%0d want 0/0/0", out_valid, out_data, pkt_cnt);
      end
      rstn = 1'b1;
      exp_pkt_cnt = 0;
      $display("test_reset done");
   endtask

   task automatic test_single();
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 64'h0000_0000_0000_0AB9;
      out_ready = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_in_ready: got %b want 1", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_latency_early: got out_valid=%b want 0", out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 28'h0000AB9 || pkt_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL single_packet: got valid=%b data=%h cnt=%0d want 1/0000ab9/1", out_valid, out_data, pkt_cnt);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || pkt_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL single_drain: got valid=%b cnt=%0d want 0/1", out_valid, pkt_cnt);
      end
      exp_pkt_cnt = 1;
      $display("test_single done: out_data=%h pkt_cnt=%0d", out_data, pkt_cnt);
   endtask

   task automatic test_straddle();
      bit to;
      int st;
      logic [27:0] exp_a[4];
      exp_a = '{28'h0000111, 28'h0000221, 28'h0000331, 28'h0000441};
      word_q = '{64'hFEE3_4413_3122_1111};
      stream(4, 0, 1'b0, 1'b0, 200, to, st);
      n_vec++;
      if (to || got_q.size() !== 4) begin
         n_err++;
         $display("FAIL straddle_first_word: got %0d packets timeout=%b want 4", got_q.size(), to);
      end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_a[i]) begin
            n_err++;
            $display("FAIL straddle_lead_%0d: got %h want %h", i, got_q[i], exp_a[i]);
         end
      end
      word_q = '{64'h0000_0000_0000_0C0F};
      stream(1, 0, 1'b0, 1'b0, 200, to, st);
      n_vec++;
      if (to || got_q.size() !== 1 || got_q[0] !== 28'hC0FFEE3) begin
         n_err++;
         $display("FAIL straddle_packet: got n=%0d data=%h want 1 x c0ffee3", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : 28'h0);
      end
      exp_pkt_cnt += 5;
      n_vec++;
      if (pkt_cnt !== 32'(exp_pkt_cnt)) begin
         n_err++;
         $display("FAIL straddle_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt);
      end
      $display("test_straddle done: pkt_cnt=%0d", pkt_cnt);
   endtask

   task automatic test_backpressure();
      bit to;
      int st;
      logic [63:0] w;
      exp_q.delete();
      word_q.delete();
      for (int n = 0; n < 2; n++) begin
         w = '0;
         for (int j = 0; j < 5; j++) begin
            w[12*j +: 12] = {8'(8'hA0 + 5 * n + j), 4'h1};
            exp_q.push_back({16'h0, 8'(8'hA0 + 5 * n + j), 4'h1});
         end
         word_q.push_back(w);
      end
      stream(10, 10, 1'b0, 1'b0, 300, to, st);
      n_vec++;
      if (st < 10) begin
         n_err++;
         $display("FAIL bp_in_ready_low: got %0d stalled cycles want >= 10", st);
      end
      n_vec++;
      if (to || got_q.size() !== 10) begin
         n_err++;
         $display("FAIL bp_count: got %0d packets timeout=%b want 10", got_q.size(), to);
      end
      n_vec++;
      if (got_cyc.size() == 0 || got_cyc[0] !== 10) begin
         n_err++;
         $display("FAIL bp_first_release: got cycle %0d want 10", got_cyc.size() > 0 ? got_cyc[0] : -1);
      end
      for (int i = 0; i < 10 && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL bp_data_%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      exp_pkt_cnt += 10;
      n_vec++;
      if (pkt_cnt !== 32'(exp_pkt_cnt)) begin
         n_err++;
         $display("FAIL bp_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt);
      end
      $display("test_backpressure done: stalls=%0d packets=%0d", st, got_q.size());
   endtask

   task automatic test_back_to_back();
      bit to;
      int st;
      word_q = '{64'h0000_0000_0444_4444};
      stream(7, 0, 1'b0, 1'b0, 200, to, st);
      n_vec++;
      if (to || got_q.size() !== 7) begin
         n_err++;
         $display("FAIL b2b_count: got %0d packets timeout=%b want 7", got_q.size(), to);
      end
      for (int i = 0; i < got_q.size() && i < 7; i++) begin
         n_vec++;
         if (got_q[i] !== 28'h0000004 || got_cyc[i] !== got_cyc[0] + i) begin
            n_err++;
            $display("FAIL b2b_%0d: got %h at cycle %0d want 0000004 at cycle %0d",
                     i, got_q[i], got_cyc[i], got_cyc[0] + i);
         end
      end
      exp_pkt_cnt += 7;
      n_vec++;
      if (pkt_cnt !== 32'(exp_pkt_cnt)) begin
         n_err++;
         $display("FAIL b2b_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt);
      end
      $display("test_back_to_back done: packets=%0d", got_q.size());
   endtask

   task automatic test_reset_midstream();
      bit to;
      int st;
      word_q = '{64'hFEE3_4413_3122_1111};
      stream(4, 0, 1'b0, 1'b0, 200, to, st);
      n_vec++;
      if (to || got_q.size() !== 4) begin
         n_err++;
         $display("FAIL midreset_lead: got %0d packets want 4", got_q.size());
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_in_ready: got %b want 0", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || pkt_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL midreset_state: got valid=%b cnt=%0d want 0/0", out_valid, pkt_cnt);
      end
      rstn = 1'b1;
      exp_pkt_cnt = 0;
      word_q = '{64'h0000_0000_0000_0AB9};
      stream(1, 0, 1'b0, 1'b0, 200, to, st);
      n_vec++;
      if (to || got_q.size() !== 1 || got_q[0] !== 28'h0000AB9 || pkt_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL midreset_clean: got n=%0d data=%h cnt=%0d want 1 x 0000ab9 cnt 1",
                  got_q.size(), got_q.size() > 0 ? got_q[0] : 28'h0, pkt_cnt);
      end
      exp_pkt_cnt = 1;
      $display("test_reset_midstream done: pkt_cnt=%0d", pkt_cnt);
   endtask

   task automatic test_random(input int npkt);
      bit stream_q[$];
      bit to;
      int st;
      int len;
      int bad = 0;
      logic [3:0]  hdr;
      logic [23:0] data;
      logic [27:0] full;
      logic [27:0] p;
      logic [63:0] w;
      exp_q.delete();
      for (int i = 0; i < npkt; i++) begin
         if ($urandom_range(15) == 0 && (64 - stream_q.size() % 64) >= 4) begin
            do stream_q.push_back(1'b0); while (stream_q.size() % 64 != 0);
         end
         hdr  = 4'($urandom_range(1, 15));
         len  = 4 + (hdr[0] ? 8 : 0) + (hdr[1] ? 16 : 0);
         data = 24'($urandom);
         full = {data, hdr};
         p    = full & ((28'd1 << len) - 28'd1);
         exp_q.push_back(p);
         for (int b = 0; b < len; b++) stream_q.push_back(p[b]);
      end
      while (stream_q.size() % 64 != 0) stream_q.push_back(1'b0);
      word_q.delete();
      for (int n = 0; n < stream_q.size() / 64; n++) begin
         for (int b = 0; b < 64; b++) w[b] = stream_q[64 * n + b];
         word_q.push_back(w);
      end
      stream(npkt, 0, 1'b1, 1'b1, 60000, to, st);
      n_vec++;
      if (to || got_q.size() !== npkt) begin
         n_err++;
         $display("FAIL random_count: got %0d packets timeout=%b want %0d", got_q.size(), to, npkt);
      end
      for (int i = 0; i < npkt && i < got_q.size(); i++) begin
         n_vec++;
         if (got_q[i] !== exp_q[i]) begin
            n_err++;
            bad++;
            $display("FAIL random_pkt_%0d: got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      exp_pkt_cnt += npkt;
      n_vec++;
      if (pkt_cnt !== 32'(exp_pkt_cnt)) begin
         n_err++;
         $display("FAIL random_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt_cnt);
      end
      $display("test_random done: %0d packets, %0d words, %0d bad", got_q.size(), word_q.size(), bad);
   endtask

   initial begin
      rstn = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_straddle();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      test_random(10000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
